// File: rtl/lane_request_encoder.sv
// lane_request_encoder
// Latches per-lane service requests and presents one 2-bit lane code at a
// time, picked round-robin after the last served lane, under a valid/ack
// handshake. All outputs come straight from registers.
//
// Handshake: valid stays high with code stable until an ack is accepted. An
// ack counts only on a rising edge where valid is high and valid has been high
// for at least HOLD_MIN cycles, counting the current one. Any other ack is
// dropped and not remembered. valid falls in the cycle after the accepted ack,
// and it stays low for at least one cycle before the next grant.
module lane_request_encoder #(
    parameter int HOLD_MIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] code,
    output logic       valid,
    output logic [3:0] pending,
    output logic [0:0] state_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    localparam logic [3:0] HOLD_MIN_C = 4'(HOLD_MIN);
    localparam logic [3:0] HOLD_MAX   = 4'd15;

    logic [0:0] state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] last_q, last_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [3:0] hold_q, hold_d;

    logic       accept;
    logic [3:0] clr;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;

    // Ack acceptance and the one-hot clear it produces.
    always_comb begin
        accept = (state_q == PRESENT) && ack && (hold_q >= HOLD_MIN_C);
        clr    = 4'b0000;
        if (accept) begin
            clr = 4'b0001 << code_q;
        end
        // A request in the same cycle as the clear re-pends the lane.
        pending_d = (pending_q & ~clr) | req;
    end

    // Round-robin search: start one lane after the last served lane and wrap.
    always_comb begin
        sel   = last_q + 2'd1;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = last_q + 2'd1 + 2'(i);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic for the grant FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        code_d  = code_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pending_q != 4'b0000) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                    hold_d  = 4'd1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end
                if (accept) begin
                    last_d  = code_q;
                    valid_d = 1'b0;
                    hold_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                hold_d  = 4'd0;
            end
        endcase
    end

    // State registers; last resets to lane 3 so the first search starts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            last_q    <= 2'b11;
            code_q    <= 2'b00;
            valid_q   <= 1'b0;
            hold_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            hold_q    <= hold_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_lane_request_encoder.sv
// Directed bench for lane_request_encoder: a table of per-cycle vectors plus
// hand-written sequences for async reset and early ack (HOLD_MIN=3 instance).
module tb_lane_request_encoder;

    typedef struct {
        logic       rst_before;
        logic [3:0] req;
        logic       ack;
        logic [1:0] exp_code;
        logic       exp_valid;
        logic [3:0] exp_pending;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pending;
    logic [0:0] state;

    logic [3:0] req3;
    logic       ack3;
    logic [1:0] code3;
    logic       valid3;
    logic [3:0] pending3;
    logic [0:0] state3;

    int n_tests;
    int n_fail;
    vec_t vecs[$];

    lane_request_encoder #(.HOLD_MIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .code(code), .valid(valid), .pending(pending), .state_o(state)
    );

    lane_request_encoder #(.HOLD_MIN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .ack(ack3),
        .code(code3), .valid(valid3), .pending(pending3), .state_o(state3)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, then release synchronously before the next edge.
    task automatic do_reset(input bit check_now);
        #2;
        rst_n = 1'b0;
        #1;
        if (check_now) begin
            check("async_rst code", {2'b00, code}, 4'b0000);
            check("async_rst valid", {3'b000, valid}, 4'b0000);
            check("async_rst pending", pending, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic add(input logic rb, input logic [3:0] r, input logic a,
                       input logic [1:0] c, input logic v, input logic [3:0] p);
        vec_t t;
        t.rst_before  = rb;
        t.req         = r;
        t.ack         = a;
        t.exp_code    = c;
        t.exp_valid   = v;
        t.exp_pending = p;
        vecs.push_back(t);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        ack     = 1'b0;
        req3    = 4'b0000;
        ack3    = 1'b0;

        // Single request: lane 2, ack at the second valid cycle; then ack in IDLE.
        add(0, 4'b0100, 0, 2'b00, 0, 4'b0100);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b0100);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b0100);
        add(0, 4'b0000, 1, 2'b10, 0, 4'b0000);
        add(0, 4'b0000, 1, 2'b10, 0, 4'b0000);
        add(0, 4'b0000, 0, 2'b10, 0, 4'b0000);
        // Round-robin from reset: 0,1,2,3 then 0,3 after req=1001.
        add(1, 4'b1111, 0, 2'b00, 0, 4'b1111);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b1111);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b1111);
        add(0, 4'b0000, 1, 2'b00, 0, 4'b1110);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b1110);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b1110);
        add(0, 4'b0000, 1, 2'b01, 0, 4'b1100);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b1100);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b1100);
        add(0, 4'b0000, 1, 2'b10, 0, 4'b1000);
        add(0, 4'b0000, 0, 2'b11, 1, 4'b1000);
        add(0, 4'b0000, 0, 2'b11, 1, 4'b1000);
        add(0, 4'b0000, 1, 2'b11, 0, 4'b0000);
        add(0, 4'b1001, 0, 2'b11, 0, 4'b1001);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b1001);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b1001);
        add(0, 4'b0000, 1, 2'b00, 0, 4'b1000);
        add(0, 4'b0000, 0, 2'b11, 1, 4'b1000);
        add(0, 4'b0000, 0, 2'b11, 1, 4'b1000);
        add(0, 4'b0000, 1, 2'b11, 0, 4'b0000);
        // Set wins over clear: lane 1 re-requested with its ack, granted after lane 2.
        add(1, 4'b0110, 0, 2'b00, 0, 4'b0110);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0110);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0110);
        add(0, 4'b0010, 1, 2'b01, 0, 4'b0110);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b0110);
        add(0, 4'b0000, 0, 2'b10, 1, 4'b0110);
        add(0, 4'b0000, 1, 2'b10, 0, 4'b0010);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0010);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0010);
        add(0, 4'b0000, 1, 2'b01, 0, 4'b0000);
        // Stability: req during PRESENT does not move code; next grant is lane 1.
        add(1, 4'b0001, 0, 2'b00, 0, 4'b0001);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b0001);
        add(0, 4'b0010, 0, 2'b00, 1, 4'b0011);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b0011);
        add(0, 4'b0000, 1, 2'b00, 0, 4'b0010);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0010);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0010);
        add(0, 4'b0000, 1, 2'b01, 0, 4'b0000);

        // Reset state
        #1;
        check("reset code", {2'b00, code}, 4'b0000);
        check("reset valid", {3'b000, valid}, 4'b0000);
        check("reset pending", pending, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven vectors
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) begin
                do_reset(1'b0);
            end
            req = vecs[i].req;
            ack = vecs[i].ack;
            step();
            check($sformatf("v%0d code", i), {2'b00, code}, {2'b00, vecs[i].exp_code});
            check($sformatf("v%0d valid", i), {3'b000, valid}, {3'b000, vecs[i].exp_valid});
            check($sformatf("v%0d pending", i), pending, vecs[i].exp_pending);
        end
        req = 4'b0000;
        ack = 1'b0;

        // Reset mid-PRESENT with code=10: outputs clear without a clock edge.
        do_reset(1'b0);
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        check("pre_rst code", {2'b00, code}, 4'b0010);
        check("pre_rst valid", {3'b000, valid}, 4'b0001);
        do_reset(1'b1);
        check("post_rst valid", {3'b000, valid}, 4'b0000);
        check("post_rst pending", pending, 4'b0000);

        // Early ack on HOLD_MIN=3 instance: acks on valid cycles 1 and 2 dropped.
        req3 = 4'b1000;
        step();
        req3 = 4'b0000;
        step();
        check("early code", {2'b00, code3}, 4'b0011);
        check("early valid", {3'b000, valid3}, 4'b0001);
        ack3 = 1'b1;
        step();
        check("early ack1 valid", {3'b000, valid3}, 4'b0001);
        check("early ack1 code", {2'b00, code3}, 4'b0011);
        check("early ack1 pending", pending3, 4'b1000);
        step();
        check("early ack2 valid", {3'b000, valid3}, 4'b0001);
        check("early ack2 pending", pending3, 4'b1000);
        step();
        ack3 = 1'b0;
        check("early ack3 valid", {3'b000, valid3}, 4'b0000);
        check("early ack3 pending", pending3, 4'b0000);
        step();
        check("early idle valid", {3'b000, valid3}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lane_request_encoder.md
# lane_request_encoder

Sequential 4-to-2 request encoder for the traffic light controller. Collects per-lane service requests (vehicle sensors / pedestrian buttons), latches them, and presents one 2-bit lane code at a time, chosen by round-robin priority, under a valid/ack handshake. It is the encoding end of the 2-bit lane-select path: the phase sequencer acks a code once the lane is served, and the code is decoded downstream into one-hot lane enables.

## Interface
- HOLD_MIN, default 2, minimum number of cycles `valid` must have been high (including the current cycle) before an `ack` is accepted; legal range 1..15.

- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  lane requests; bit i is sampled every rising edge, and a 1 sets pending[i]
- ack  input  1  single-cycle pulse from the consumer: presented lane has been served
- code  output  2  encoded lane number (0..3); registered
- valid  output  1  code is meaningful and awaiting ack; registered
- pending  output  4  latched, not-yet-served requests; registered

## Operation
- Registers: pending[3:0], last[1:0] (last served lane), code[1:0], valid, hold_cnt[3:0] (saturating), state ∈ {IDLE, PRESENT}.
- Pending update every cycle: pending_next = (pending & ~clr) | req, where clr is one-hot(code) when an ack is accepted, and 0 otherwise.
  - A req bit high in the clear cycle re-pends that lane (set wins).
  - A level-held req therefore re-requests continuously.
- Round-robin select: search pending (registered value) starting at lane (last+1) mod 4, ascending with wrap; first set bit wins.
- IDLE: valid=0.
  - If pending≠0: code←selected lane, valid←1, hold_cnt←1, state←PRESENT.
  - Otherwise stay in IDLE; code holds its previous value.
- PRESENT: valid=1 and code stable; hold_cnt increments, saturating at 15.
  - ack is accepted iff hold_cnt ≥ HOLD_MIN.
  - On an accepted ack: clear pending[code] (subject to the set-wins rule), last←code, valid←0, state←IDLE.
  - An ack that is not accepted is ignored and is not remembered.
- ack in IDLE is ignored.
- Requests arriving during PRESENT never change code. They are only considered at the next IDLE decision.
- Reset (asynchronous, any state): pending=0000, valid=0, code=00, last=11 (so the first search starts at lane 0), hold_cnt=0, state=IDLE.

## Timing
- Request latency: req sampled at edge k → pending set after edge k → code/valid updated after edge k+1. valid is therefore high during cycle k+2.
- Minimum grant period: HOLD_MIN cycles in PRESENT, plus 1 IDLE cycle. With HOLD_MIN=2, back-to-back grants have valid low for exactly one cycle between them.
- ack is sampled at the rising edge. valid falls in the cycle after an accepted ack.
- All outputs are registered; there is no combinational path from input to output.
- When rst_n is asserted, outputs take their reset values immediately, regardless of clk. Release is synchronous to the next clk edge; the first decision can happen one edge after release.

## Test plan
- Reset mid-PRESENT: with valid=1 and code=10, pulse rst_n low between edges → valid=0, code=00 and pending=0000 immediately, with no clock edge needed.
- Single request: pulse req=0100 for one cycle at edge k → pending=0100 after k; code=10 and valid=1 after k+1; ack at HOLD_MIN → pending=0000, valid=0 the next cycle.
- Round-robin: req=1111 for one cycle from reset → grants appear in order 0,1,2,3, each with one IDLE cycle between. Then req=1001 after lane 3 is served → next code=0, then 3.
- Early ack: HOLD_MIN=3; ack on the first valid cycle → ignored, code unchanged, valid stays 1. ack on the third valid cycle → accepted.
- Set wins over clear: while code=01, assert req[1] in the same cycle as the accepted ack → pending[1] remains 1, and lane 1 is granted again only after the other pending lanes (round-robin from last=1).
- Stability: while code=00 is valid, pulse req=0010 → code stays 00 until ack; the next grant is 01.
